mem_arbiter: RTL and testbench

Two-port arbiter that sits directly upstream of the memory block. It merges the instruction-fetch port and the data (operand) port onto the single memory request port, which uses the mem_read/mem_write strobes and the read_ack/write_ack acknowledges. It issues one-cycle strobes and waits for the acknowledge, in either registered-ack or immediate-ack memory mode. It reports a nonexistent-memory error when no acknowledge arrives before a timeout.

---
 rtl/mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: merges the instruction-fetch port and the data port onto a
// single memory request port. One transaction is in flight at a time; each
// one issues a single-cycle mem_read/mem_write strobe and then waits for
// the matching acknowledge. If no acknowledge arrives within TIMEOUT wait
// cycles, the transaction completes with err set and rdata zeroed.
//
// Parameters
//   IACK_MODE  0: acks are registered and read data is valid with read_ack
//              1: acks are immediate and read data is valid the cycle after
//   TIMEOUT    wait cycles before nonexistent memory is reported (1..255)
//   PADDR_W    physical address width
//   WORD_W     memory word width
//
// Ports
//   clk, reset                       clock, asynchronous active-low reset
//   if_addr/if_read                  fetch request (level, held until if_ack)
//   if_ack/if_err/if_rdata           fetch completion, error and data
//   d_addr/d_read/d_write/d_wdata    data request (level, held until d_ack)
//   d_ack/d_err/d_rdata              data completion, error and data
//   mem_addr/mem_write_data          address and write data to memory
//   mem_read/mem_write               single-cycle strobes to memory
//   mem_read_data/read_ack/write_ack memory read data and acknowledges
module mem_arbiter #(
  parameter bit          IACK_MODE = 1'b0,
  parameter int unsigned TIMEOUT   = 15,
  parameter int unsigned PADDR_W   = 24,
  parameter int unsigned WORD_W    = 36
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PADDR_W-1:0] if_addr,
  input  logic               if_read,
  output logic               if_ack,
  output logic               if_err,
  output logic [WORD_W-1:0]  if_rdata,
  input  logic [PADDR_W-1:0] d_addr,
  input  logic               d_read,
  input  logic               d_write,
  input  logic [WORD_W-1:0]  d_wdata,
  output logic               d_ack,
  output logic               d_err,
  output logic [WORD_W-1:0]  d_rdata,
  output logic [PADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0]  mem_write_data,
  output logic               mem_read,
  output logic               mem_write,
  input  logic [WORD_W-1:0]  mem_read_data,
  input  logic               read_ack,
  input  logic               write_ack
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_RESP
  } state_t;

  state_t              state, state_n;
  logic                grant_d;   // 1: data port owns the current transaction
  logic                last_d;    // 1: data port was granted most recently
  logic                op_wr;     // latched operation is a write
  logic                err_q;
  logic [PADDR_W-1:0]  addr_q;
  logic [WORD_W-1:0]   wdata_q;
  logic [WORD_W-1:0]   rdata_q;
  logic [7:0]          cnt;

  logic req_i, req_d, sel_d, latch, cap, tmo, cnt_inc, ack_ok;

  always_comb begin
    state_n = state;
    latch   = 1'b0;
    cap     = 1'b0;
    tmo     = 1'b0;
    cnt_inc = 1'b0;
    req_i   = if_read;
    req_d   = d_read | d_write;
    // On a tie the port that was not granted last wins.
    sel_d   = (req_i && req_d) ? ~last_d : req_d;
    ack_ok  = op_wr ? write_ack : read_ack;

    case (state)
      S_IDLE: begin
        if (req_i || req_d) begin
          latch   = 1'b1;
          state_n = S_ISSUE;
        end
      end
      S_ISSUE, S_WAIT: begin
        // An ack in the strobe cycle itself is treated like one in WAIT.
        if (ack_ok) begin
          if (op_wr) begin
            state_n = S_RESP;
          end else if (IACK_MODE) begin
            state_n = S_CAPTURE;
          end else begin
            cap     = 1'b1;
            state_n = S_RESP;
          end
        end else if (state == S_ISSUE) begin
          state_n = S_WAIT;
        end else if (cnt == 8'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th ack-less WAIT cycle.
          tmo     = 1'b1;
          state_n = S_RESP;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_CAPTURE: begin
        cap     = 1'b1;
        state_n = S_RESP;
      end
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      grant_d <= 1'b0;
      last_d  <= 1'b0;
      op_wr   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt     <= '0;
    end else begin
      state <= state_n;
      if (latch) begin
        grant_d <= sel_d;
        // Simultaneous read and write on the data port is serviced as a read.
        op_wr   <= sel_d & d_write & ~d_read;
        addr_q  <= sel_d ? d_addr : if_addr;
        wdata_q <= d_wdata;
        err_q   <= 1'b0;
        cnt     <= '0;
      end
      if (cnt_inc) begin
        cnt <= cnt + 8'd1;
      end
      if (cap) begin
        rdata_q <= mem_read_data;
      end
      if (tmo) begin
        err_q   <= 1'b1;
        rdata_q <= '0;
      end
      if (state == S_RESP) begin
        last_d <= grant_d;
      end
    end
  end

  assign mem_read       = (state == S_ISSUE) && !op_wr;
  assign mem_write      = (state == S_ISSUE) &&  op_wr;
  assign mem_addr       = addr_q;
  assign mem_write_data = wdata_q;
  assign if_ack         = (state == S_RESP) && !grant_d;
  assign d_ack          = (state == S_RESP) &&  grant_d;
  assign if_err         = (state == S_RESP) && !grant_d && err_q;
  assign d_err          = (state == S_RESP) &&  grant_d && err_q;
  assign if_rdata       = rdata_q;
  assign d_rdata        = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: instance 0 uses registered-ack memory,
// instance 1 immediate-ack memory, each with its own small memory model.
module tb_mem_arbiter;
  localparam int AW  = 24;
  localparam int DW  = 36;
  localparam int TMO = 15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          if_read [2];
  logic [AW-1:0] if_addr [2];
  logic          d_read  [2];
  logic          d_write [2];
  logic [AW-1:0] d_addr  [2];
  logic [DW-1:0] d_wdata [2];
  logic          if_ack  [2];
  logic          if_err  [2];
  logic          d_ack   [2];
  logic          d_err   [2];
  logic [DW-1:0] if_rdata[2];
  logic [DW-1:0] d_rdata [2];
  logic [AW-1:0] mem_addr[2];
  logic [DW-1:0] mem_wd  [2];
  logic [DW-1:0] mem_rd  [2];
  logic          mem_read [2];
  logic          mem_write[2];
  logic          read_ack [2];
  logic          write_ack[2];
  logic          mem_en [2];
  logic          inj_ra [2];
  logic          inj_wa [2];

  int nvec = 0;
  int nerr = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic          ra_q = 1'b0;
    logic          wa_q = 1'b0;
    logic [DW-1:0] rd_q = '0;
    logic [DW-1:0] store [4096];

    mem_arbiter #(
      .IACK_MODE(g != 0),
      .TIMEOUT  (TMO),
      .PADDR_W  (AW),
      .WORD_W   (DW)
    ) u_dut (
      .clk           (clk),
      .reset         (rst_n),
      .if_addr       (if_addr[g]),
      .if_read       (if_read[g]),
      .if_ack        (if_ack[g]),
      .if_err        (if_err[g]),
      .if_rdata      (if_rdata[g]),
      .d_addr        (d_addr[g]),
      .d_read        (d_read[g]),
      .d_write       (d_write[g]),
      .d_wdata       (d_wdata[g]),
      .d_ack         (d_ack[g]),
      .d_err         (d_err[g]),
      .d_rdata       (d_rdata[g]),
      .mem_addr      (mem_addr[g]),
      .mem_write_data(mem_wd[g]),
      .mem_read      (mem_read[g]),
      .mem_write     (mem_write[g]),
      .mem_read_data (mem_rd[g]),
      .read_ack      (read_ack[g]),
      .write_ack     (write_ack[g])
    );

    initial for (int i = 0; i < 4096; i++) store[i] = '0;

    always @(posedge clk) begin
      if (mem_write[g] && mem_en[g]) store[mem_addr[g][11:0]] <= mem_wd[g];
      if (mem_read[g]) rd_q <= store[mem_addr[g][11:0]];
      ra_q <= mem_read[g] && mem_en[g];
      wa_q <= mem_write[g] && mem_en[g];
    end

    if (g == 0) begin : g_reg
      assign read_ack[g]  = ra_q | inj_ra[g];
      assign write_ack[g] = wa_q | inj_wa[g];
    end else begin : g_imm
      assign read_ack[g]  = (mem_read[g] && mem_en[g]) | inj_ra[g];
      assign write_ack[g] = (mem_write[g] && mem_en[g]) | inj_wa[g];
    end
    assign mem_rd[g] = rd_q;
  end

  typedef struct {
    int            k;       // instance
    bit            port_d;  // 1: data port, 0: fetch port
    bit            rd;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    bit            mem_on;
    int            lat;
    bit            err;
    logic [DW-1:0] rdata;
    int            nrd;
    int            nwr;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if_read[k] = 1'b0; if_addr[k] = '0; d_read[k] = 1'b0; d_write[k] = 1'b0;
      d_addr[k] = '0; d_wdata[k] = '0; mem_en[k] = 1'b1; inj_ra[k] = 1'b0; inj_wa[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic chk_zero(input string nm, input int k);
    chk({nm, " if_ack"},   if_ack[k],    0);
    chk({nm, " d_ack"},    d_ack[k],     0);
    chk({nm, " d_err"},    d_err[k],     0);
    chk({nm, " mem_read"}, mem_read[k],  0);
    chk({nm, " mem_wr"},   mem_write[k], 0);
    chk({nm, " mem_addr"}, mem_addr[k],  0);
    chk({nm, " mem_wd"},   mem_wd[k],    0);
    chk({nm, " rdata"},    d_rdata[k],   0);
  endtask

  // Starts at a sample point in an IDLE cycle (cycle 0); returns at the
  // sample point of the IDLE cycle following the ack.
  task automatic apply_vec(input string nm, input vec_t v);
    int k, lat, nrd, nwr, wrong;
    logic err;
    logic [DW-1:0] rd;
    k = v.k; lat = -1; nrd = 0; nwr = 0; wrong = 0; err = 1'b0; rd = '0;
    mem_en[k] = v.mem_on;
    if (v.port_d) begin
      d_addr[k] = v.addr; d_wdata[k] = v.wdata; d_read[k] = v.rd; d_write[k] = v.wr;
    end else begin
      if_addr[k] = v.addr; if_read[k] = 1'b1;
    end
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (mem_read[k])  nrd++;
      if (mem_write[k]) nwr++;
      if (v.port_d ? if_ack[k] : d_ack[k]) wrong++;
      if (v.port_d ? d_ack[k] : if_ack[k]) begin
        lat = n;
        err = v.port_d ? d_err[k] : if_err[k];
        rd  = v.port_d ? d_rdata[k] : if_rdata[k];
        break;
      end
    end
    if_read[k] = 1'b0; d_read[k] = 1'b0; d_write[k] = 1'b0; mem_en[k] = 1'b1;
    chk({nm, " latency"}, lat, v.lat);
    chk({nm, " err"}, err, v.err);
    if (v.rd || !v.port_d) chk({nm, " rdata"}, rd, v.rdata);
    chk({nm, " read strobes"}, nrd, v.nrd);
    chk({nm, " write strobes"}, nwr, v.nwr);
    chk({nm, " other-port acks"}, wrong, 0);
    @(posedge clk); #1;
  endtask

  // Transaction-level reference: one transaction at a time, granted only in
  // a free cycle, round-robin on ties, fixed latency per operation type.
  task automatic run_random(input int k, input int ncyc);
    bit            act [2];
    bit            op_w[2];
    logic [AW-1:0] ra  [2];
    logic [DW-1:0] rw  [2];
    logic [DW-1:0] refm[8];
    bit            busy, g_w;
    int            free_at, ack_at, gp, last, sel;
    int            exp_nrd, exp_nwr, nrd, nwr;
    logic [DW-1:0] exp_rd;
    bit            e_i, e_d;
    busy = 0; g_w = 0; free_at = 0; ack_at = 0; gp = 0; last = 0;
    exp_nrd = 0; exp_nwr = 0; nrd = 0; nwr = 0; exp_rd = '0;
    for (int i = 0; i < 8; i++) refm[i] = '0;
    for (int p = 0; p < 2; p++) begin act[p] = 0; op_w[p] = 0; ra[p] = '0; rw[p] = '0; end
    do_reset();
    for (int c = 0; c < ncyc + 400; c++) begin
      e_i = busy && ack_at == c && gp == 0;
      e_d = busy && ack_at == c && gp == 1;
      chk("rnd if_ack", if_ack[k], e_i);
      chk("rnd d_ack", d_ack[k], e_d);
      if (mem_read[k])  nrd++;
      if (mem_write[k]) nwr++;
      if (busy && ack_at == c) begin
        if (!g_w) chk("rnd rdata", gp == 1 ? d_rdata[k] : if_rdata[k], exp_rd);
        chk("rnd err", gp == 1 ? d_err[k] : if_err[k], 0);
        busy = 0; free_at = c + 1; last = gp; act[gp] = 0;
        if (gp == 0) if_read[k] = 1'b0;
        else begin d_read[k] = 1'b0; d_write[k] = 1'b0; end
      end
      if (c < ncyc) begin
        for (int p = 0; p < 2; p++) begin
          if (!act[p] && $urandom_range(2) == 0) begin
            act[p] = 1;
            ra[p]  = {12'($urandom), 9'h100, 3'($urandom)};
            rw[p]  = {4'($urandom), 32'($urandom)};
            if (p == 0) begin
              op_w[p] = 0; if_addr[k] = ra[p]; if_read[k] = 1'b1;
            end else begin
              sel = $urandom_range(2);
              op_w[p] = (sel == 1);
              d_addr[k] = ra[p]; d_wdata[k] = rw[p];
              d_read[k] = (sel != 1); d_write[k] = (sel != 0);
            end
          end
        end
      end
      if (!busy && c >= free_at && (act[0] || act[1])) begin
        gp   = (act[0] && act[1]) ? (last == 0 ? 1 : 0) : (act[1] ? 1 : 0);
        g_w  = op_w[gp];
        busy = 1;
        ack_at = c + ((g_w && k == 1) ? 2 : 3);
        if (g_w) begin refm[ra[gp][2:0]] = rw[gp]; exp_nwr++; end
        else begin exp_rd = refm[ra[gp][2:0]]; exp_nrd++; end
      end
      if (c >= ncyc && !busy && !act[0] && !act[1]) break;
      @(posedge clk); #1;
    end
    chk("rnd drained", {busy, act[0], act[1]}, 0);
    chk("rnd read strobes", nrd, exp_nrd);
    chk("rnd write strobes", nwr, exp_nwr);
  endtask

  vec_t tbl[12];
  vec_t v;

  initial begin
    //          k port rd wr addr          wdata           on lat err rdata          nrd nwr
    tbl[0]  = '{0, 1, 0, 1, 24'h001000, 36'h123456789, 1, 3,  0, 36'h0,          0, 1};
    tbl[1]  = '{0, 1, 1, 0, 24'h001000, 36'h0,         1, 3,  0, 36'h123456789,  1, 0};
    tbl[2]  = '{0, 1, 1, 1, 24'h001000, 36'hFFFFFFFFF, 1, 3,  0, 36'h123456789,  1, 0};
    tbl[3]  = '{0, 0, 1, 0, 24'h001000, 36'h0,         1, 3,  0, 36'h123456789,  1, 0};
    tbl[4]  = '{1, 1, 0, 1, 24'h000200, 36'h0ABCDEF01, 1, 2,  0, 36'h0,          0, 1};
    tbl[5]  = '{1, 0, 1, 0, 24'h000200, 36'h0,         1, 3,  0, 36'h0ABCDEF01,  1, 0};
    tbl[6]  = '{1, 1, 1, 1, 24'h000200, 36'h000000005, 1, 3,  0, 36'h0ABCDEF01,  1, 0};
    tbl[7]  = '{0, 1, 1, 0, 24'h001000, 36'h0,         0, 17, 1, 36'h0,          1, 0};
    tbl[8]  = '{1, 0, 1, 0, 24'h000200, 36'h0,         0, 17, 1, 36'h0,          1, 0};
    tbl[9]  = '{1, 1, 0, 1, 24'h000200, 36'h777777777, 0, 17, 1, 36'h0,          0, 1};
    tbl[10] = '{0, 1, 1, 0, 24'h001000, 36'h0,         1, 3,  0, 36'h123456789,  1, 0};
    tbl[11] = '{1, 0, 1, 0, 24'h000200, 36'h0,         1, 3,  0, 36'h0ABCDEF01,  1, 0};

    do_reset();
    chk_zero("reset0", 0);
    chk_zero("reset1", 1);

    for (int i = 0; i < 12; i++) apply_vec($sformatf("vec%0d", i), tbl[i]);

    // Both ports requesting continuously: D, I, D, I every 4 cycles.
    do_reset();
    if_addr[0] = 24'h001000; if_read[0] = 1'b1;
    d_addr[0]  = 24'h000200; d_read[0]  = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      @(posedge clk); #1;
      chk($sformatf("alt c%0d if_ack", n), if_ack[0], (n == 7 || n == 15));
      chk($sformatf("alt c%0d d_ack", n), d_ack[0], (n == 3 || n == 11));
    end
    if_read[0] = 1'b0; d_read[0] = 1'b0;
    @(posedge clk); #1;

    // Timeout followed by a late read_ack in the IDLE cycle.
    v = tbl[7];
    apply_vec("tmo", v);
    inj_ra[0] = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      inj_ra[0] = 1'b0;
      chk("late ack d_ack", d_ack[0], 0);
      chk("late ack strobe", mem_read[0] | mem_write[0], 0);
    end
    v = tbl[10];
    apply_vec("after late ack", v);

    // Reset asserted in WAIT abandons the access.
    mem_en[0] = 1'b0;
    d_addr[0] = 24'h001000; d_wdata[0] = 36'h000000ABC; d_read[0] = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk("pre-reset mem_addr", mem_addr[0], 24'h001000);
    #2 rst_n = 1'b0;
    #1 chk_zero("async reset", 0);
    d_read[0] = 1'b0; mem_en[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    inj_ra[0] = 1'b1;
    @(posedge clk); #1;
    inj_ra[0] = 1'b0;
    chk("stray ack d_ack", d_ack[0], 0);
    chk("stray ack if_ack", if_ack[0], 0);
    v = tbl[3];
    apply_vec("post-reset fetch", v);

    run_random(0, 400);
    run_random(1, 400);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
